// File: rtl/shift_arbiter_ctrl.sv
// Two-requester round-robin arbiter in front of a shared combinational barrel shifter.
// Each grant runs IDLE -> SHIFT -> HOLD; the result is held until the consumer takes it.
module shift_arbiter_ctrl #(
  parameter int SW = 26,
  parameter int EW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Req0_i,
  input  logic [SW-1:0] Data0_i,
  input  logic          LR0_i,
  input  logic [EW-1:0] Shift0_i,
  input  logic          Req1_i,
  input  logic [SW-1:0] Data1_i,
  input  logic          LR1_i,
  input  logic [EW-1:0] Shift1_i,
  output logic          Ack0_o,
  output logic          Ack1_o,
  output logic [SW-1:0] Shft_Data_o,
  output logic          Shft_LR_o,
  output logic [EW-1:0] Shft_Value_o,
  input  logic [SW-1:0] Shft_Result_i,
  output logic [SW-1:0] Result_o,
  output logic          Id_o,
  output logic          Valid_o,
  input  logic          Ready_i,
  output logic          Busy_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t state;
  logic   last_gnt;  // requester granted most recently
  logic   gid;       // requester owning the operation in flight
  logic   gnt_any;
  logic   gnt_sel;

  // On a tie, the requester that did not win last time goes next.
  always_comb begin
    gnt_any = Req0_i | Req1_i;
    gnt_sel = Req1_i;
    if (Req0_i && Req1_i) gnt_sel = ~last_gnt;
  end

  assign Busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_gnt     <= 1'b1;
      gid          <= 1'b0;
      Ack0_o       <= 1'b0;
      Ack1_o       <= 1'b0;
      Shft_Data_o  <= '0;
      Shft_LR_o    <= 1'b0;
      Shft_Value_o <= '0;
      Result_o     <= '0;
      Id_o         <= 1'b0;
      Valid_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state        <= SHIFT;
            gid          <= gnt_sel;
            last_gnt     <= gnt_sel;
            Ack0_o       <= ~gnt_sel;
            Ack1_o       <= gnt_sel;
            Shft_Data_o  <= gnt_sel ? Data1_i  : Data0_i;
            Shft_LR_o    <= gnt_sel ? LR1_i    : LR0_i;
            Shft_Value_o <= gnt_sel ? Shift1_i : Shift0_i;
          end
        end
        SHIFT: begin
          Ack0_o   <= 1'b0;
          Ack1_o   <= 1'b0;
          Result_o <= Shft_Result_i;
          Id_o     <= gid;
          Valid_o  <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (Ready_i) begin
            Valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Bench for shift_arbiter_ctrl: behavioural barrel shifter plus a scoreboard of
// expected {id, result} pairs pushed when requests are driven.
module tb_shift_arbiter_ctrl;
  localparam int SW = 26;
  localparam int EW = 5;

  logic          clk;
  logic          rst;
  logic          Req0_i, LR0_i, Req1_i, LR1_i, Ready_i;
  logic [SW-1:0] Data0_i, Data1_i;
  logic [EW-1:0] Shift0_i, Shift1_i;
  logic          Ack0_o, Ack1_o, Shft_LR_o, Id_o, Valid_o, Busy_o;
  logic [SW-1:0] Shft_Data_o, Shft_Result_i, Result_o;
  logic [EW-1:0] Shft_Value_o;

  typedef struct {logic id; logic [SW-1:0] res;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  shift_arbiter_ctrl #(.SW(SW), .EW(EW)) dut (
    .clk(clk), .rst(rst),
    .Req0_i(Req0_i), .Data0_i(Data0_i), .LR0_i(LR0_i), .Shift0_i(Shift0_i),
    .Req1_i(Req1_i), .Data1_i(Data1_i), .LR1_i(LR1_i), .Shift1_i(Shift1_i),
    .Ack0_o(Ack0_o), .Ack1_o(Ack1_o),
    .Shft_Data_o(Shft_Data_o), .Shft_LR_o(Shft_LR_o), .Shft_Value_o(Shft_Value_o),
    .Shft_Result_i(Shft_Result_i),
    .Result_o(Result_o), .Id_o(Id_o), .Valid_o(Valid_o), .Ready_i(Ready_i),
    .Busy_o(Busy_o)
  );

  // Shared shifter sitting outside the block
  assign Shft_Result_i = Shft_LR_o ? (Shft_Data_o << Shft_Value_o) : (Shft_Data_o >> Shft_Value_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; Req0_i = 1; Req1_i = 1; Ready_i = 1;
    Data0_i = 26'h3FFFFFF; LR0_i = 1; Shift0_i = 5'd31;
    Data1_i = 26'h1234567; LR1_i = 1; Shift1_i = 5'd3;
    repeat (2) begin
      tick;
      checks++;
      if ({Ack0_o, Ack1_o, Valid_o, Busy_o, Id_o, Shft_LR_o} !== 6'b0 || Result_o !== '0 ||
          Shft_Data_o !== '0 || Shft_Value_o !== '0) begin
        errors++;
        $display("FAIL reset_outputs ack0=%b ack1=%b valid=%b busy=%b id=%b lr=%b res=%h sdata=%h sval=%0d want all 0",
                 Ack0_o, Ack1_o, Valid_o, Busy_o, Id_o, Shft_LR_o, Result_o, Shft_Data_o, Shft_Value_o);
      end
    end
    rst = 0; Req0_i = 0; Req1_i = 0; Ready_i = 0;
    tick;
    checks++;
    if (Busy_o !== 1'b0 || Ack0_o !== 1'b0 || Ack1_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b ack0=%b ack1=%b want 0 0 0", Busy_o, Ack0_o, Ack1_o);
    end
  endtask

  task automatic test_single;
    Req0_i = 1; Data0_i = 26'h0000001; LR0_i = 1; Shift0_i = 5'd5;
    exp_q.push_back('{id: 1'b0, res: 26'h0000020});
    tick;
    checks++;
    if (Ack0_o !== 1'b1 || Ack1_o !== 1'b0 || Shft_Value_o !== 5'd5 || Shft_LR_o !== 1'b1 || Busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_ack ack0=%b ack1=%b sval=%0d lr=%b busy=%b want 1 0 5 1 1",
               Ack0_o, Ack1_o, Shft_Value_o, Shft_LR_o, Busy_o);
    end
    Req0_i = 0;
    tick;
    checks++;
    if (Valid_o !== 1'b1 || Ack0_o !== 1'b0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL single_valid valid=%b ack0=%b q=%0d want 1 0 >0", Valid_o, Ack0_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (Result_o !== e.res || Id_o !== e.id) begin
        errors++;
        $display("FAIL single_result res=%h id=%b want %h %b", Result_o, Id_o, e.res, e.id);
      end
    end
    Ready_i = 1;
    tick;
    Ready_i = 0;
    checks++;
    if (Valid_o !== 1'b0 || Busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_release valid=%b busy=%b want 0 0", Valid_o, Busy_o);
    end
  endtask

  task automatic test_pass_through;
    Req1_i = 1; Data1_i = 26'h2AAAAAA; LR1_i = 0; Shift1_i = 5'd0;
    exp_q.push_back('{id: 1'b1, res: 26'h2AAAAAA});
    tick;
    checks++;
    if (Ack1_o !== 1'b1 || Ack0_o !== 1'b0) begin
      errors++;
      $display("FAIL pass_ack ack1=%b ack0=%b want 1 0", Ack1_o, Ack0_o);
    end
    Req1_i = 0;
    tick;
    checks++;
    if (Valid_o !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL pass_valid valid=%b q=%0d want 1 >0", Valid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (Result_o !== e.res || Id_o !== e.id) begin
        errors++;
        $display("FAIL pass_result res=%h id=%b want %h %b", Result_o, Id_o, e.res, e.id);
      end
    end
    Ready_i = 1;
    tick;
    Ready_i = 0;
    tick;
    checks++;
    if (Shft_Data_o !== 26'h2AAAAAA || Shft_Value_o !== 5'd0 || Busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_retain sdata=%h sval=%0d busy=%b want 2aaaaaa 0 0", Shft_Data_o, Shft_Value_o, Busy_o);
    end
  endtask

  task automatic test_fairness;
    logic found;
    int last_valid;
    rst = 1;
    tick;
    rst = 0;
    Req0_i = 1; Data0_i = 26'h0000003; LR0_i = 1; Shift0_i = 5'd4;
    Req1_i = 1; Data1_i = 26'h3000000; LR1_i = 0; Shift1_i = 5'd8;
    Ready_i = 1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{id: k[0], res: k[0] ? 26'h0030000 : 26'h0000030});
    last_valid = 0;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int w = 0; w < 6 && !found; w++) begin
        tick;
        if (Ack0_o || Ack1_o) found = 1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL fair_ack_timeout op=%0d no ack within 6 cycles", k);
      end else begin
        checks++;
        if ({Ack1_o, Ack0_o} !== (k[0] ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL fair_grant op=%0d ack1ack0=%b want %b", k, {Ack1_o, Ack0_o}, k[0] ? 2'b10 : 2'b01);
        end
      end
      if (k == 3) begin Req0_i = 0; Req1_i = 0; end
      tick;
      checks++;
      if (Valid_o !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL fair_valid op=%0d valid=%b q=%0d want 1 >0", k, Valid_o, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (Result_o !== e.res || Id_o !== e.id) begin
          errors++;
          $display("FAIL fair_result op=%0d res=%h id=%b want %h %b", k, Result_o, Id_o, e.res, e.id);
        end
        if (k > 0) begin
          checks++;
          if (cyc - last_valid != 3) begin
            errors++;
            $display("FAIL fair_spacing op=%0d gap=%0d want 3", k, cyc - last_valid);
          end
        end
        last_valid = cyc;
      end
    end
    tick;
    Ready_i = 0;
    exp_q.delete();
  endtask

  task automatic test_back_pressure;
    Req0_i = 1; Data0_i = 26'h0ABCDEF; LR0_i = 0; Shift0_i = 5'd4;
    exp_q.push_back('{id: 1'b0, res: 26'h00ABCDE});
    tick;
    checks++;
    if (Ack0_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_ack0 ack0=%b want 1", Ack0_o);
    end
    Req0_i = 0;
    Req1_i = 1; Data1_i = 26'h0000001; LR1_i = 1; Shift1_i = 5'd25;
    tick;
    checks++;
    if (Valid_o !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL bp_valid valid=%b q=%0d want 1 >0", Valid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (Result_o !== e.res || Id_o !== e.id) begin
        errors++;
        $display("FAIL bp_result res=%h id=%b want %h %b", Result_o, Id_o, e.res, e.id);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) Req0_i = 1;  // short-lived request that is never sampled in IDLE
      if (i == 3) Req0_i = 0;
      tick;
      checks++;
      if (Valid_o !== 1'b1 || Result_o !== 26'h00ABCDE || Id_o !== 1'b0 || Ack0_o !== 1'b0 ||
          Ack1_o !== 1'b0 || Busy_o !== 1'b1 || Shft_Value_o !== 5'd4) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b res=%h id=%b ack0=%b ack1=%b busy=%b sval=%0d want 1 0abcde 0 0 0 1 4",
                 i, Valid_o, Result_o, Id_o, Ack0_o, Ack1_o, Busy_o, Shft_Value_o);
      end
    end
    Ready_i = 1;
    exp_q.push_back('{id: 1'b1, res: 26'h2000000});
    tick;
    Ready_i = 0;
    checks++;
    if (Valid_o !== 1'b0 || Busy_o !== 1'b0 || Ack1_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release valid=%b busy=%b ack1=%b want 0 0 0", Valid_o, Busy_o, Ack1_o);
    end
    tick;
    checks++;
    if (Ack1_o !== 1'b1 || Ack0_o !== 1'b0 || Shft_Value_o !== 5'd25) begin
      errors++;
      $display("FAIL bp_ack1 ack1=%b ack0=%b sval=%0d want 1 0 25", Ack1_o, Ack0_o, Shft_Value_o);
    end
    Req1_i = 0;
    tick;
    checks++;
    if (Valid_o !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL bp_valid2 valid=%b q=%0d want 1 >0", Valid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (Result_o !== e.res || Id_o !== e.id) begin
        errors++;
        $display("FAIL bp_result2 res=%h id=%b want %h %b", Result_o, Id_o, e.res, e.id);
      end
    end
    Ready_i = 1;
    tick;
    Ready_i = 0;
  endtask

  task automatic test_reset_mid_op;
    Req0_i = 1; Data0_i = 26'h3FFFFFF; LR0_i = 0; Shift0_i = 5'd31;
    tick;
    checks++;
    if (Ack0_o !== 1'b1 || Shft_Value_o !== 5'd31) begin
      errors++;
      $display("FAIL mid_ack ack0=%b sval=%0d want 1 31", Ack0_o, Shft_Value_o);
    end
    rst = 1;
    tick;
    rst = 0;
    checks++;
    if (Ack0_o !== 1'b0 || Valid_o !== 1'b0 || Busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ack0=%b valid=%b busy=%b want 0 0 0", Ack0_o, Valid_o, Busy_o);
    end
    exp_q.push_back('{id: 1'b0, res: 26'h0000000});
    tick;
    checks++;
    if (Ack0_o !== 1'b1 || Valid_o !== 1'b0 || Shft_Value_o !== 5'd31) begin
      errors++;
      $display("FAIL mid_reack ack0=%b valid=%b sval=%0d want 1 0 31", Ack0_o, Valid_o, Shft_Value_o);
    end
    Req0_i = 0;
    tick;
    checks++;
    if (Valid_o !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL mid_valid valid=%b q=%0d want 1 >0", Valid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (Result_o !== e.res || Id_o !== e.id) begin
        errors++;
        $display("FAIL mid_result res=%h id=%b want %h %b", Result_o, Id_o, e.res, e.id);
      end
    end
    Ready_i = 1;
    tick;
    Ready_i = 0;
  endtask

  initial begin
    rst = 1; Req0_i = 0; Req1_i = 0; Ready_i = 0;
    Data0_i = '0; Data1_i = '0; LR0_i = 0; LR1_i = 0; Shift0_i = '0; Shift1_i = '0;
    test_reset;
    test_single;
    test_pass_through;
    test_fairness;
    test_back_pressure;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_arbiter_ctrl.md
SHIFT_ARBITER_CTRL -- requirements
Module: shift_arbiter_ctrl

Interface
REQ-001 SHALL have parameter SW, default 26: shifter data width in bits.
REQ-002 SHALL have parameter EW, default 5: shift-amount width in bits.
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-004 SHALL have ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Req0_i  in  1  requester 0 (alignment) request
Data0_i  in  SW  requester 0 operand
LR0_i  in  1  requester 0 direction (1 = left, 0 = right)
Shift0_i  in  EW  requester 0 shift amount
Req1_i  in  1  requester 1 (normalization) request
Data1_i  in  SW  requester 1 operand
LR1_i  in  1  requester 1 direction
Shift1_i  in  EW  requester 1 shift amount
Ack0_o  out  1  requester 0 accepted, one-cycle pulse
Ack1_o  out  1  requester 1 accepted, one-cycle pulse
Shft_Data_o  out  SW  registered operand to shared barrel shifter
Shft_LR_o  out  1  registered direction to shifter
Shft_Value_o  out  EW  registered shift amount to shifter
Shft_Result_i  in  SW  combinational shifter output
Result_o  out  SW  registered shift result
Id_o  out  1  requester that owns Result_o
Valid_o  out  1  Result_o valid
Ready_i  in  1  consumer accepts Result_o
Busy_o  out  1  high when state is not IDLE

Function
REQ-005 SHALL implement FSM states IDLE, SHIFT, HOLD; all outputs except Busy_o SHALL be registered.
REQ-006 In IDLE with any Req sampled high at edge T: grant one requester, load its Data/LR/Shift into Shft_* registers, go to SHIFT at T+1.
REQ-007 When only one Req is high, that requester SHALL be granted.
REQ-008 When both are high: grant the requester not granted last (round-robin); last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-009 Ack0_o/Ack1_o SHALL pulse for exactly the one cycle spent in SHIFT, only for the granted requester; never both in the same cycle.
REQ-010 Requesters SHALL hold Req, Data, LR and Shift stable until their Ack. Req sampled only in IDLE; Req high in SHIFT/HOLD SHALL NOT cause a grant or Ack.
REQ-011 In SHIFT: at end of cycle, capture Shft_Result_i into Result_o and grant id into Id_o; go to HOLD with Valid_o=1 (Req edge T -> Valid_o high from T+2).
REQ-012 In HOLD: Result_o, Id_o, Valid_o, Shft_* SHALL stay stable until Ready_i sampled high; then go to IDLE, with Valid_o low from the next cycle.
REQ-013 Ready_i SHALL be ignored outside HOLD; Ready_i may already be high on the first HOLD cycle (single-cycle HOLD).
REQ-014 Minimum issue interval SHALL be 3 cycles (IDLE, SHIFT, HOLD); a new grant SHALL be possible in the first IDLE cycle after HOLD.
REQ-015 Shft_* registers SHALL retain the last issued operand while idle; Shft_Value_o=0 SHALL pass data through unchanged (shifter property, no special casing).
REQ-016 Shift amounts up to 2^EW-1 SHALL be forwarded unmodified; no saturation or clamping in this block.
REQ-017 A Req dropped before being sampled in IDLE SHALL produce no Ack and no result.

Reset
REQ-018 rst high at an edge SHALL force IDLE; Valid_o, Ack0_o, Ack1_o, Id_o = 0; Result_o, Shft_Data_o, Shft_Value_o = 0; Shft_LR_o = 0; last-grant pointer = 1.
REQ-019 rst in SHIFT or HOLD SHALL abort the operation: no Ack pulse or Valid_o after reset; pending requests re-arbitrate from the first IDLE cycle after rst falls.

Verification
REQ-020 Reset: rst high 2 cycles with both Req high -> all outputs 0, Busy_o=0, no Ack during reset.
REQ-021 Single op with real shifter model: Req0_i=1, Data0_i=26'h0000001, LR0_i=1, Shift0_i=5 at edge T -> Ack0_o=1 at T+1, Shft_Value_o=5; Valid_o=1 at T+2, Result_o=26'h0000020, Id_o=0.
REQ-022 Fairness: Req0_i and Req1_i held high, Ready_i=1 -> grant order 0,1,0,1; Ack pulses never overlap; each result ends 3 cycles after the previous.
REQ-023 Backpressure: Ready_i=0 for 4 cycles in HOLD, Req1_i high -> Result_o, Id_o, Valid_o stable, no Ack1_o; Ready_i=1 -> IDLE, then Ack1_o two cycles later.
REQ-024 Reset mid-op: rst pulsed in SHIFT -> Valid_o stays 0; after release with Req0_i high, fresh Ack0_o 1 cycle later (IDLE sample then SHIFT).
REQ-025 Pass-through: Shift1_i=0, Data1_i=26'h2AAAAAA, LR1_i=0 -> Result_o=26'h2AAAAAA, Id_o=1.
